// File: rtl/fetch_pc_unit.sv
// Fetch / next-PC stage for the single-cycle MIPS core.
// Owns the PC, fetches one instruction per FETCH/EXEC pair over a
// req/ready handshake, resolves the next PC from decoder flags and
// latches a sticky fault (HALT) on invalid instructions, fetch timeouts
// and misaligned jr targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        branch_eq,
  input  logic        branch_neq,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        invalid_inst,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic        halted,
  output logic [1:0]  fault_code,
  output logic [31:0] epc
);

  localparam int unsigned    CW      = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam bit             TO_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [CW-1:0]  TO_LAST = TO_EN ? CW'(FETCH_TIMEOUT - 1) : '0;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_INVALID = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;
  localparam logic [1:0] F_JR_ALGN = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr;
  logic [31:0]     r_epc;
  logic [1:0]      r_fault;
  logic [CW-1:0]   r_cnt;

  logic [31:0]     w_pc4;
  logic [31:0]     w_jtarget;
  logic [31:0]     w_btarget;
  logic            w_taken;
  logic            w_timeout;

  // Next-PC candidates, all mod 2^32
  always_comb begin
    w_pc4     = r_pc + 32'd4;
    w_jtarget = {w_pc4[31:28], r_instr[25:0], 2'b00};
    w_btarget = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    w_taken   = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);
    w_timeout = TO_EN && (r_cnt == TO_LAST);
  end

  // Fetch/exec/halt sequencing with PC, instruction and fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_epc   <= '0;
      r_fault <= F_NONE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end else if (w_timeout) begin
            r_fault <= F_TIMEOUT;
            r_epc   <= r_pc;
            r_state <= S_HALT;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (invalid_inst) begin
            r_fault <= F_INVALID;
            r_epc   <= r_pc;
            r_state <= S_HALT;
          end else if (jump_reg) begin
            if (rs_data[1:0] != 2'b00) begin
              r_fault <= F_JR_ALGN;
              r_epc   <= r_pc;
              r_state <= S_HALT;
            end else begin
              r_pc    <= rs_data;
              r_state <= S_FETCH;
            end
          end else if (jump) begin
            r_pc    <= w_jtarget;
            r_state <= S_FETCH;
          end else if (w_taken) begin
            r_pc    <= w_btarget;
            r_state <= S_FETCH;
          end else begin
            r_pc    <= w_pc4;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Reset parks the state in FETCH, so the request is gated by rst_n directly
  assign imem_req    = rst_n && (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign link_addr   = w_pc4;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);
  assign fault_code  = r_fault;
  assign epc         = r_epc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table,
// hand-written timeout/reset sequences and randomized instruction
// streams checked against a behavioural next-PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        branch_eq;
  logic        branch_neq;
  logic        jump;
  logic        jump_reg;
  logic        invalid_inst;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic        halted;
  logic [1:0]  fault_code;
  logic [31:0] epc;

  fetch_pc_unit #(
    .RESET_PC      (RST_PC),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .link_addr    (link_addr),
    .branch_eq    (branch_eq),
    .branch_neq   (branch_neq),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .invalid_inst (invalid_inst),
    .alu_zero     (alu_zero),
    .rs_data      (rs_data),
    .halted       (halted),
    .fault_code   (fault_code),
    .epc          (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          jr;
    bit          j;
    bit          beq;
    bit          bne;
    bit          inv;
    bit          zero;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic [1:0]  exp_fault;
    int unsigned dly;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] rdata, input bit jr, input bit j,
                              input bit beq, input bit bne, input bit inv, input bit zero,
                              input logic [31:0] rs, input logic [31:0] epc_v,
                              input logic [1:0] ef, input int unsigned dly);
    vec_t v;
    v.rdata = rdata; v.jr = jr; v.j = j; v.beq = beq; v.bne = bne;
    v.inv = inv; v.zero = zero; v.rs = rs; v.exp_pc = epc_v;
    v.exp_fault = ef; v.dly = dly;
    return v;
  endfunction

  // Reference next-PC rules from the ISA description, plain arithmetic
  function automatic void ref_next(input logic [31:0] cur, input vec_t v,
                                   output logic [31:0] npc, output logic [1:0] f);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(v.rdata[15:0]));
    f   = 2'd0;
    npc = seq;
    if (v.inv) begin
      f = 2'd1; npc = cur;
    end else if (v.jr) begin
      if (v.rs % 4 != 0) begin f = 2'd3; npc = cur; end
      else npc = v.rs;
    end else if (v.j) begin
      npc = (seq & 32'hF000_0000) + (v.rdata % 32'h0400_0000) * 4;
    end else if ((v.beq && v.zero) || (v.bne && !v.zero)) begin
      npc = seq + 32'(off * 4);
    end
  endfunction

  task automatic clear_flags();
    branch_eq = 0; branch_neq = 0; jump = 0; jump_reg = 0;
    invalid_inst = 0; alu_zero = 0; rs_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("rst_req",    32'(imem_req), 32'd0);
    chk("rst_pc",     pc, RST_PC);
    chk("rst_addr",   imem_addr, RST_PC);
    chk("rst_instr",  instr, 32'd0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault",  32'(fault_code), 32'd0);
    chk("rst_epc",    epc, 32'd0);
    @(posedge clk); #1;
    chk("rst_req_hold", 32'(imem_req), 32'd0);
    chk("rst_pc_hold",  pc, RST_PC);
    clear_flags();
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    m_pc = RST_PC;
  endtask

  // One instruction: optional stall cycles, accept, EXEC, check the outcome
  task automatic run_instr(input vec_t v);
    logic [31:0] old_pc;
    old_pc = m_pc;
    for (int unsigned k = 0; k < v.dly; k++) begin
      imem_ready = 1'b0;
      chk("stall_req",   32'(imem_req), 32'd1);
      chk("stall_valid", 32'(instr_valid), 32'd0);
      chk("stall_addr",  imem_addr, old_pc);
      @(posedge clk); #1;
    end
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, old_pc);
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    @(posedge clk); #1;
    imem_rdata = $urandom;
    chk("exec_valid",  32'(instr_valid), 32'd1);
    chk("exec_req",    32'(imem_req), 32'd0);
    chk("exec_instr",  instr, v.rdata);
    chk("exec_pc",     pc, old_pc);
    chk("exec_link",   link_addr, old_pc + 32'd4);
    chk("exec_halted", 32'(halted), 32'd0);
    // ready left high during EXEC must be ignored
    branch_eq = v.beq; branch_neq = v.bne; jump = v.j; jump_reg = v.jr;
    invalid_inst = v.inv; alu_zero = v.zero; rs_data = v.rs;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    clear_flags();
    chk("post_valid", 32'(instr_valid), 32'd0);
    chk("post_fault", 32'(fault_code), 32'(v.exp_fault));
    if (v.exp_fault != 2'd0) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc",   pc, old_pc);
      chk("halt_epc",  epc, old_pc);
      chk("halt_req",  32'(imem_req), 32'd0);
    end else begin
      chk("next_pc",   pc, v.exp_pc);
      chk("run_flag",  32'(halted), 32'd0);
      chk("next_req",  32'(imem_req), 32'd1);
      m_pc = v.exp_pc;
    end
  endtask

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] npc;
    logic [1:0]  f;

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    clear_flags();

    //            rdata         jr j beq bne inv z  rs            exp_pc        f  dly
    tbl[0]  = mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0004, 0, 0);
    tbl[1]  = mk(32'h8C01_0004, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0008, 0, 1);
    tbl[2]  = mk(32'h0000_0020, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0000_000C, 0, 3);
    tbl[3]  = mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h10,       32'h0000_0010, 0, 0);
    tbl[4]  = mk(32'h1000_FFFF, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0000_0010, 0, 0);
    tbl[5]  = mk(32'h1400_0003, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0000_0020, 0, 0);
    tbl[6]  = mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h10,       32'h0000_0010, 0, 0);
    tbl[7]  = mk(32'h1000_FFFF, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0000_0014, 0, 0);
    tbl[8]  = mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h4000_0008, 32'h4000_0008, 0, 0);
    tbl[9]  = mk(32'h0C00_0040, 0, 1, 0, 0, 0, 0, 32'h0,        32'h4000_0100, 0, 0);
    tbl[10] = mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h80,       32'h0000_0080, 0, 0);
    tbl[11] = mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
    tbl[12] = mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0000, 0, 0);
    tbl[13] = mk(32'h1000_0002, 0, 0, 1, 1, 0, 1, 32'h0,        32'h0000_000C, 0, 0);
    tbl[14] = mk(32'h0800_0100, 1, 1, 0, 0, 0, 0, 32'h24,       32'h0000_0024, 0, 0);
    tbl[15] = mk(32'hFC00_0000, 0, 0, 1, 0, 1, 1, 32'h0,        32'h0000_0024, 1, 0);

    do_reset();
    for (int i = 0; i < 16; i++) run_instr(tbl[i]);

    // HALT is sticky and ignores memory
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_req",    32'(imem_req), 32'd0);
      chk("hold_pc",     pc, 32'h24);
      chk("hold_epc",    epc, 32'h24);
      chk("hold_fault",  32'(fault_code), 32'd1);
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_instr",  instr, 32'hFC00_0000);
    end
    imem_ready = 1'b0;

    // Misaligned jr target
    do_reset();
    run_instr(mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h40, 32'h40, 0, 0));
    run_instr(mk(32'h0200_0008, 1, 0, 0, 0, 0, 0, 32'h81, 32'h40, 3, 0));

    // Fetch timeout after exactly 4 FETCH cycles with ready low
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("to_not_yet", 32'(halted), 32'd0);
      chk("to_req",     32'(imem_req), 32'd1);
    end
    @(posedge clk); #1;
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_fault",  32'(fault_code), 32'd2);
    chk("to_epc",    epc, 32'h0);
    chk("to_pc",     pc, 32'h0);
    chk("to_req_off", 32'(imem_req), 32'd0);

    // Ready rising on the 4th FETCH cycle is accepted
    do_reset();
    run_instr(mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4, 0, 3));

    // Reset mid-FETCH (pc = 8, stalled one cycle)
    run_instr(mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0, 32'h8, 0, 0));
    @(posedge clk); #1;
    chk("midf_pc", pc, 32'h8);
    do_reset();

    // Reset mid-EXEC with a jump pending: no PC update
    run_instr(mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4, 0, 0));
    imem_ready = 1'b1; imem_rdata = 32'h0800_0400;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    chk("mide_valid", 32'(instr_valid), 32'd1);
    jump = 1'b1; jump_reg = 1'b1; rs_data = 32'h0000_1000;
    do_reset();
    run_instr(mk(32'h0000_0020, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4, 0, 0));

    // Randomized streams against the reference model
    for (int n = 0; n < 250; n++) begin
      v.rdata = $urandom;
      v.inv   = ($urandom_range(0, 24) == 0);
      v.jr    = ($urandom_range(0, 5) == 0);
      v.j     = ($urandom_range(0, 4) == 0);
      v.beq   = $urandom_range(0, 1) == 1;
      v.bne   = $urandom_range(0, 1) == 1;
      v.zero  = $urandom_range(0, 1) == 1;
      v.rs    = $urandom;
      if ($urandom_range(0, 7) != 0) v.rs[1:0] = 2'b00;
      v.dly   = $urandom_range(0, 3);
      ref_next(m_pc, v, npc, f);
      v.exp_pc    = npc;
      v.exp_fault = f;
      run_instr(v);
      if (f != 2'd0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch and next-PC stage directly upstream of the instruction decoder/control unit in the single-cycle MIPS core.
- Owns the PC register and fetches each instruction from instruction memory with a req/ready handshake.
- Presents the latched instruction to decode for one EXEC cycle.
- Consumes the decoder's branch/jump/invalid flags plus the ALU zero flag and rs value, and computes the next PC.
- Stops in a sticky HALT state on any fault.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
FETCH_TIMEOUT, 16, max FETCH cycles without imem_ready before fault; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  fetch address (= pc)
imem_req  output  1  fetch request, high in FETCH only; forced 0 while rst_n low
imem_ready  input  1  memory returns imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  latched instruction, stable through EXEC
instr_valid  output  1  high for exactly the EXEC cycle; decode/datapath commit only then
pc  output  32  current PC
link_addr  output  32  pc+4, used for the jal $ra write
branch_eq  input  1  beq decoded
branch_neq  input  1  bne decoded
jump  input  1  j/jal decoded
jump_reg  input  1  jr decoded
invalid_inst  input  1  decoder flags undefined opcode/funct
alu_zero  input  1  ALU result == 0
rs_data  input  32  register rs value, jr target
halted  output  1  sticky, high in HALT
fault_code  output  2  00 none, 01 invalid instr, 10 fetch timeout, 11 misaligned jr target
epc  output  32  PC of the faulting instruction/fetch

Behaviour:
- Reset (async, rst_n low):
  - State = FETCH; pc = RESET_PC; instr = 0; instr_valid = 0; halted = 0; fault_code = 00; epc = 0; timeout counter = 0.
  - imem_req = 0 while rst_n is low. First request is issued in the first cycle after rst_n deasserts.
- States: FETCH, EXEC, HALT. instr_valid and halted are decodes of the state register.
- FETCH:
  - imem_req = 1.
  - If imem_ready: instr <= imem_rdata; counter <= 0; next state EXEC.
  - Else: counter increments.
  - If FETCH_TIMEOUT != 0 and counter == FETCH_TIMEOUT-1 with ready still low: HALT, fault_code 10, epc <= pc.
  - Minimum latency is 2 cycles per instruction (ready in the first FETCH cycle, then EXEC).
- EXEC:
  - instr_valid = 1 for one cycle. The decoder sees instr; flags are sampled at the end of this cycle.
  - Next-PC priority: jump_reg > jump > taken branch > sequential.
  - jump_reg: target = rs_data. If rs_data[1:0] != 0: HALT, fault_code 11, epc <= pc, pc unchanged.
  - jump: {pc4[31:28], instr[25:0], 2'b00}.
  - Taken branch (branch_eq & alu_zero) | (branch_neq & ~alu_zero): pc4 + (sign-extended instr[15:0] << 2).
  - Otherwise: pc4. pc4 = pc + 4 with 32-bit wrap; 32'hFFFF_FFFC steps to 0. All target arithmetic is mod 2^32.
  - invalid_inst overrides all flags: HALT, fault_code 01, epc <= pc, pc unchanged.
  - Any non-fault outcome: pc updated, next state FETCH.
- HALT:
  - Terminal. imem_req = 0, instr_valid = 0, halted = 1.
  - pc, epc, fault_code and instr hold. Exit only via reset.
- Simultaneous or conflicting events:
  - branch_eq and branch_neq both high: either condition may take the branch (OR of both terms).
  - imem_ready outside FETCH is ignored.
- link_addr = pc+4 combinationally at all times.
- Reset mid-FETCH or mid-EXEC: immediate abort, no PC update, restart from RESET_PC.

Test Plan:
- Reset then sequential stream, RESET_PC=0, ready every FETCH cycle: pc steps 0,4,8,C. instr_valid is high every 2nd cycle. imem_req is 0 during reset.
- beq at pc=0x10 with imm=0xFFFF and alu_zero=1: next pc = 0x10. Same with alu_zero=0: next pc = 0x14. bne with alu_zero=0 and imm=0x0003: next pc = 0x20.
- jal at pc=0x4000_0008 with instr[25:0]=0x000_0040: next pc = 0x4000_0100, and link_addr = 0x4000_000C during EXEC. jr with rs_data=0x0000_0080: pc = 0x80. jr with rs_data=0x81: halted, fault 11, epc=pc.
- invalid_inst asserted in EXEC at pc=0x24: halted=1, fault_code=01, epc=0x24, pc holds 0x24, imem_req stays 0 afterwards.
- FETCH_TIMEOUT=4 and ready held low: HALT after exactly 4 FETCH cycles, fault 10. Ready rising on the 4th cycle is accepted with no fault.
- Wrap and reset: pc=0xFFFF_FFFC sequential steps to 0. Asserting rst_n low mid-FETCH gives immediate pc=RESET_PC and all outputs at their reset values.
